// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and state type for the stream_mux slice
package stream_mux_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   localparam int   COUNT_W    = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;
endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational round-robin pick, searching upward from ptr+1
module rr_arbiter #(
   parameter int CHANNELS = 4,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SELW-1:0]     ptr,
   output logic [SELW-1:0]     grant,
   output logic                grant_vld
);
   int idx;

   // Scan from the farthest offset down so the nearest requester after ptr is written last.
   always_comb begin
      grant = '0;
      idx   = 0;
      for (int k = CHANNELS; k >= 1; k--) begin
         idx = (int'(ptr) + k) % CHANNELS;
         if (req[idx]) grant = SELW'(idx);
      end
      grant_vld = |req;
   end
endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-channel registered stream mux, fixed or round-robin select
// Optional handshake counter output xfer_count enabled by STREAM_MUX_COUNT_EN.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef STREAM_MUX_COUNT_EN
   ,
   output logic [COUNT_W-1:0]        xfer_count
`endif
);
   state_e            state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [SELW-1:0]   chan_q, chan_d;
   logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [SELW-1:0]   rr_grant, grant;
   logic              rr_vld, grant_vld, sel_ok, load_ok;

   rr_arbiter #(.CHANNELS(CHANNELS), .SELW(SELW)) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .grant     (rr_grant),
      .grant_vld (rr_vld)
   );

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_chan  = chan_q;
   assign load_ok   = ~out_valid | out_ready;
   assign sel_ok    = (32'(sel) < CHANNELS);

   always_comb begin
      grant     = sel;
      grant_vld = sel_ok & in_valid[sel];
      if (mode == MODE_RR) begin
         grant     = rr_grant;
         grant_vld = rr_vld;
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      chan_d   = chan_q;
      rr_ptr_d = rr_ptr_q;
      in_ready = '0;
      if (load_ok) begin
         if (grant_vld) begin
            state_d         = ST_FULL;
            data_d          = in_data[int'(grant)*WIDTH +: WIDTH];
            chan_d          = grant;
            in_ready[grant] = 1'b1;
            if (mode == MODE_RR) rr_ptr_d = grant;
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   // Pointer starts at the last channel so channel 0 wins the first round-robin grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         data_q   <= '0;
         chan_q   <= '0;
         rr_ptr_q <= SELW'(CHANNELS - 1);
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         chan_q   <= chan_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef STREAM_MUX_COUNT_EN
   logic [COUNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (out_valid && out_ready && (count_q != {COUNT_W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign xfer_count = count_q;
`endif
endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - directed bench for stream_mux with hand-computed expectations
module tb_stream_mux;
   localparam int WIDTH    = 4;
   localparam int CHANNELS = 4;
   localparam int SELW     = 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode;
   logic [SELW-1:0]           sel;
   logic [WIDTH-1:0]          out_data;
   logic [SELW-1:0]           out_chan;
   logic                      out_valid;
   logic                      out_ready;
`ifdef STREAM_MUX_COUNT_EN
   logic [15:0]               xfer_count;
`endif

   int total = 0;
   int bad   = 0;

   logic [3:0] exp_data [4];
   int         rr_seq   [6];
   int         alt_seq  [4];

   stream_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef STREAM_MUX_COUNT_EN
      ,
      .xfer_count(xfer_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_data = '{4'h0, 4'h5, 4'hA, 4'hF};
      rr_seq   = '{0, 1, 2, 3, 0, 1};
      alt_seq  = '{3, 1, 3, 1};

      rst       = 1'b1;
      in_data   = {4'hF, 4'hA, 4'h5, 4'h0};
      in_valid  = 4'b0000;
      mode      = 1'b0;
      sel       = 2'd0;
      out_ready = 1'b1;
      #1;
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_chan", out_chan, 0);
      chk("reset_ready", in_ready, 0);
`ifdef STREAM_MUX_COUNT_EN
      chk("reset_count", xfer_count, 0);
`endif
      step();
      rst = 1'b0;

      // fixed select stepping 0..3
      in_valid = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         sel = SELW'(s);
         #1;
         chk($sformatf("fix_ready%0d", s), in_ready, 32'(1) << s);
         step();
         chk($sformatf("fix_data%0d", s), out_data, exp_data[s]);
         chk($sformatf("fix_chan%0d", s), out_chan, s);
         chk($sformatf("fix_valid%0d", s), out_valid, 1);
      end

      // round-robin, all valid
      mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("rr_ready%0d", i), in_ready, 32'(1) << rr_seq[i]);
         step();
         chk($sformatf("rr_chan%0d", i), out_chan, rr_seq[i]);
         chk($sformatf("rr_data%0d", i), out_data, exp_data[rr_seq[i]]);
         chk($sformatf("rr_valid%0d", i), out_valid, 1);
      end

      // round-robin, only ch1 and ch3
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("alt_ready%0d", i), in_ready, 32'(1) << alt_seq[i]);
         step();
         chk($sformatf("alt_chan%0d", i), out_chan, alt_seq[i]);
      end

      // backpressure holding the ch1 word
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp_ready%0d", i), in_ready, 0);
         step();
         chk($sformatf("bp_data%0d", i), out_data, 4'h5);
         chk($sformatf("bp_chan%0d", i), out_chan, 1);
         chk($sformatf("bp_valid%0d", i), out_valid, 1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_ready", in_ready, 4'b1000);
      step();
      chk("bp_rel_chan", out_chan, 3);
      chk("bp_rel_data", out_data, 4'hF);

      // fixed sel=2 with channel 2 idle: output drains and empties
      mode = 1'b0;
      sel  = 2'd2;
      #1;
      chk("idle_ready", in_ready, 0);
      step();
      chk("idle_valid", out_valid, 0);
      chk("idle_data_hold", out_data, 4'hF);

      // single valid channel in round-robin goes back-to-back
      mode     = 1'b1;
      in_valid = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("single_ready%0d", i), in_ready, 4'b0001);
         step();
         chk($sformatf("single_chan%0d", i), out_chan, 0);
         chk($sformatf("single_valid%0d", i), out_valid, 1);
      end

      // reset mid-stream
      in_valid = 4'b0100;
      step();
      chk("pre_rst_data", out_data, 4'hA);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_chan", out_chan, 0);
`ifdef STREAM_MUX_COUNT_EN
      chk("mid_rst_count", xfer_count, 0);
`endif
      step();
      rst      = 1'b0;
      in_valid = 4'b1111;
      #1;
      chk("post_rst_ready", in_ready, 4'b0001);
      step();
      chk("post_rst_chan0", out_chan, 0);
      chk("post_rst_valid", out_valid, 1);
      step();
      chk("post_rst_chan1", out_chan, 1);
      chk("post_rst_data1", out_data, 4'h5);
`ifdef STREAM_MUX_COUNT_EN
      chk("post_rst_count", xfer_count, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
